softmax_stream_sequencer: RTL and testbench

Initiator side of the 4-lane softmax interface. Accepts a serial valid/ready stream of logits and buffers each group of 4. It computes the group maximum on the fly, drives in1..in4/max_input with softmax_enable, and waits for softmax_output_ready. It then captures the four results and streams them out serially with a last marker. Sits between the upstream score producer and the softmax block.

---
 rtl/softmax_seq_pkg.sv | 6 +
 rtl/softmax_max_compare.sv | 24 ++
 rtl/softmax_stream_sequencer.sv | 109 ++++++++++
 tb/tb_softmax_stream_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_seq_pkg.sv
// softmax_seq_pkg: shared states and sizing for the softmax stream sequencer
package softmax_seq_pkg;
  typedef enum logic [1:0] {COLLECT, WAIT, DRAIN} state_t;
  localparam int VEC_LEN = 4;
  localparam int IDX_W = $clog2(VEC_LEN);
endpackage

// File: rtl/softmax_max_compare.sv
// softmax_max_compare: combinational a > b for signed fixed-point or sign-magnitude float words
// ports: a, b operands; gt high when a is strictly greater than b (+0 and -0 compare equal)
module softmax_max_compare #(
  parameter int ARITH_TYPE = 1,
  parameter int DATA_WIDTH = 32,
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt
);
  localparam int MW = E + M;
  logic sa, sb;
  logic [MW-1:0] ma, mb;
  assign sa = a[DATA_WIDTH-1];
  assign sb = b[DATA_WIDTH-1];
  assign ma = a[MW-1:0];
  assign mb = b[MW-1:0];
  // float: opposite signs -> positive wins unless both are zero; negatives order by smaller magnitude
  assign gt = ARITH_TYPE != 0 ? $signed(a) > $signed(b)
            : sa != sb ? !sa && (ma != '0 || mb != '0)
            : sa ? ma < mb : ma > mb;
endmodule

// File: rtl/softmax_stream_sequencer.sv
// softmax_stream_sequencer: groups 4 streamed logits, hands them with their max to a softmax block, streams results back
// ports: clk/reset (async, active-low); s_valid/s_data/s_ready logit stream in;
//   softmax_enable, sm_in1..4, sm_max to softmax; sm_out_1..4, softmax_output_ready from softmax;
//   m_valid/m_data/m_last/m_ready result stream out; busy (not collecting); timeout_err (sticky)
module softmax_stream_sequencer
  import softmax_seq_pkg::*;
#(
  parameter int ARITH_TYPE = 1,
  parameter int DATA_WIDTH = 32,
  parameter int INTEGER = 10,
  parameter int FRACTION = 22,
  parameter int E = 8,
  parameter int M = 23,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  softmax_enable,
  output logic [DATA_WIDTH-1:0] sm_in1,
  output logic [DATA_WIDTH-1:0] sm_in2,
  output logic [DATA_WIDTH-1:0] sm_in3,
  output logic [DATA_WIDTH-1:0] sm_in4,
  output logic [DATA_WIDTH-1:0] sm_max,
  input  logic [DATA_WIDTH-1:0] sm_out_1,
  input  logic [DATA_WIDTH-1:0] sm_out_2,
  input  logic [DATA_WIDTH-1:0] sm_out_3,
  input  logic [DATA_WIDTH-1:0] sm_out_4,
  input  logic                  softmax_output_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  timeout_err
);
  // the word layout of the selected number format; equals DATA_WIDTH for consistent parameters
  localparam int CMP_W = ARITH_TYPE != 0 ? INTEGER + FRACTION : 1 + E + M;
  localparam int WC_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_t state, state_nx;
  logic [IDX_W-1:0] count, idx;
  logic [DATA_WIDTH-1:0] slot [VEC_LEN];
  logic [DATA_WIDTH-1:0] res [VEC_LEN];
  logic [DATA_WIDTH-1:0] max_q;
  logic [WC_W-1:0] wcnt;
  logic gt, accept, got, tmo, out_hs;
  softmax_max_compare #(
    .ARITH_TYPE(ARITH_TYPE),
    .DATA_WIDTH(CMP_W),
    .E(E),
    .M(M)
  ) u_cmp (
    .a(s_data),
    .b(max_q),
    .gt(gt)
  );
  assign s_ready = state == COLLECT;
  assign softmax_enable = state == WAIT;
  assign m_valid = state == DRAIN;
  assign busy = state != COLLECT;
  assign m_data = res[idx];
  assign m_last = m_valid && idx == IDX_W'(VEC_LEN - 1);
  assign sm_in1 = slot[0];
  assign sm_in2 = slot[1];
  assign sm_in3 = slot[2];
  assign sm_in4 = slot[3];
  assign sm_max = max_q;
  assign accept = s_valid && s_ready;
  assign got = softmax_enable && softmax_output_ready;
  assign tmo = TIMEOUT != 0 && int'(wcnt) == TIMEOUT - 1;
  assign out_hs = m_valid && m_ready;
  always_comb begin
    state_nx = state == COLLECT ? (accept && count == IDX_W'(VEC_LEN - 1) ? WAIT : COLLECT)
             : state == WAIT ? (softmax_output_ready ? DRAIN : tmo ? COLLECT : WAIT)
             : (out_hs && m_last ? COLLECT : DRAIN);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
      count <= '0;
      idx <= '0;
      wcnt <= '0;
      max_q <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) begin
        slot[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      state <= state_nx;
      wcnt <= softmax_enable ? wcnt + 1'b1 : '0;
      if (accept) begin
        slot[count] <= s_data;
        max_q <= count == '0 || gt ? s_data : max_q;
        count <= count + 1'b1;
      end
      if (got) begin
        res[0] <= sm_out_1;
        res[1] <= sm_out_2;
        res[2] <= sm_out_3;
        res[3] <= sm_out_4;
      end
      if (softmax_enable && !softmax_output_ready && tmo) timeout_err <= 1'b1;
      if (out_hs) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_softmax_stream_sequencer.sv
// tb_softmax_stream_sequencer: directed plus random groups on a fixed-point and a float instance against a max/order model
module tb_softmax_stream_sequencer;
  logic clk = 0, reset = 0, s_valid = 0, softmax_output_ready = 0, m_ready = 0;
  logic [31:0] s_data = 0, sm_out_1 = 0, sm_out_2 = 0, sm_out_3 = 0, sm_out_4 = 0;
  logic s_ready, softmax_enable, m_valid, m_last, busy, timeout_err;
  logic [31:0] sm_in1, sm_in2, sm_in3, sm_in4, sm_max, m_data;
  logic s_ready_f, softmax_enable_f, m_valid_f, m_last_f, busy_f, timeout_err_f;
  logic [31:0] sm_in1_f, sm_in2_f, sm_in3_f, sm_in4_f, sm_max_f, m_data_f;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  softmax_stream_sequencer #(.ARITH_TYPE(1), .TIMEOUT(8)) u_fix (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .softmax_enable(softmax_enable), .sm_in1(sm_in1), .sm_in2(sm_in2), .sm_in3(sm_in3),
    .sm_in4(sm_in4), .sm_max(sm_max), .sm_out_1(sm_out_1), .sm_out_2(sm_out_2),
    .sm_out_3(sm_out_3), .sm_out_4(sm_out_4), .softmax_output_ready(softmax_output_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .timeout_err(timeout_err));

  softmax_stream_sequencer #(.ARITH_TYPE(0), .TIMEOUT(8)) u_flt (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_f),
    .softmax_enable(softmax_enable_f), .sm_in1(sm_in1_f), .sm_in2(sm_in2_f), .sm_in3(sm_in3_f),
    .sm_in4(sm_in4_f), .sm_max(sm_max_f), .sm_out_1(sm_out_1), .sm_out_2(sm_out_2),
    .sm_out_3(sm_out_3), .sm_out_4(sm_out_4), .softmax_output_ready(softmax_output_ready),
    .m_valid(m_valid_f), .m_data(m_data_f), .m_last(m_last_f), .m_ready(m_ready), .busy(busy_f),
    .timeout_err(timeout_err_f));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // float ordering as signed magnitude: both zeros map to 0 and therefore compare equal
  function automatic longint fkey(input logic [31:0] x);
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction

  function automatic logic [31:0] max_fix(input logic [31:0] d [4]);
    logic [31:0] m = d[0];
    for (int i = 1; i < 4; i++) if ($signed(d[i]) > $signed(m)) m = d[i];
    return m;
  endfunction

  function automatic logic [31:0] max_flt(input logic [31:0] d [4]);
    logic [31:0] m = d[0];
    for (int i = 1; i < 4; i++) if (fkey(d[i]) > fkey(m)) m = d[i];
    return m;
  endfunction

  task automatic chk_reset_state();
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_enable", 32'(softmax_enable), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_sm_max", sm_max, 0);
    chk("rst_sm_in1", sm_in1, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_f_max", sm_max_f, 0);
  endtask

  // called at a negedge in COLLECT; returns at the negedge after the 4th accept
  task automatic send_group(input logic [31:0] d [4]);
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      while (!s_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("s_ready_bound", 32'(t < 50), 1);
      s_valid = 1;
      s_data = d[i];
      @(negedge clk);
    end
    s_valid = 0;
    s_data = $urandom;
    chk("enable_after_4th", 32'(softmax_enable), 1);
    chk("s_ready_in_wait", 32'(s_ready), 0);
    chk("busy_in_wait", 32'(busy), 1);
    chk("sm_in1", sm_in1, d[0]);
    chk("sm_in2", sm_in2, d[1]);
    chk("sm_in3", sm_in3, d[2]);
    chk("sm_in4", sm_in4, d[3]);
    chk("sm_max_fixed", sm_max, max_fix(d));
    chk("sm_max_float", sm_max_f, max_flt(d));
  endtask

  // holds ready low for k WAIT cycles, then raises it for one cycle with results r
  task automatic respond(input int k, input logic [31:0] r [4]);
    sm_out_1 = r[0];
    sm_out_2 = r[1];
    sm_out_3 = r[2];
    sm_out_4 = r[3];
    for (int i = 0; i < k; i++) begin
      chk("enable_held", 32'(softmax_enable), 1);
      @(negedge clk);
    end
    chk("enable_before_ready", 32'(softmax_enable), 1);
    softmax_output_ready = 1;
    @(negedge clk);
    softmax_output_ready = 0;
    chk("m_valid_after_ready", 32'(m_valid), 1);
    chk("enable_dropped", 32'(softmax_enable), 0);
  endtask

  // mode 0: random m_ready, 1: alternating 0/1; stops after n handshakes
  task automatic drain(input logic [31:0] r [4], input int n, input int mode);
    int k = 0, t = 0;
    while (k < n && t < 100) begin
      chk("m_valid", 32'(m_valid), 1);
      chk("m_data", m_data, r[k]);
      chk("m_last", 32'(m_last), 32'(k == 3));
      chk("m_data_float_inst", m_data_f, r[k]);
      m_ready = mode == 1 ? t[0] : 1'($urandom_range(0, 1));
      if (m_ready) k++;
      @(negedge clk);
      t++;
    end
    m_ready = 0;
    chk("drain_bound", 32'(t < 100), 1);
  endtask

  task automatic full_group(input logic [31:0] d [4], input logic [31:0] r [4], input int k, input int mode);
    send_group(d);
    respond(k, r);
    drain(r, 4, mode);
    chk("collect_after_drain", 32'(s_ready), 1);
    chk("m_valid_idle", 32'(m_valid), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    logic [31:0] d [4];
    logic [31:0] r [4];
    repeat (2) @(negedge clk);
    chk_reset_state();
    reset = 1;
    @(negedge clk);
    d = '{32'h00400000, 32'h00800000, 32'hFFC00000, 32'h00000000};
    r = '{32'h11, 32'h22, 32'h33, 32'h44};
    full_group(d, r, 5, 1);
    d = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h80000000};
    full_group(d, r, 2, 0);
    d = '{32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hC0800000};
    full_group(d, r, 0, 0);
    d = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'h80000000};
    full_group(d, r, 1, 0);
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = $urandom;
        r[i] = $urandom;
      end
      full_group(d, r, int'($urandom_range(0, 6)), 0);
    end
    // ready high throughout COLLECT must be ignored, then honoured on the first WAIT cycle
    r = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    sm_out_1 = r[0];
    sm_out_2 = r[1];
    sm_out_3 = r[2];
    sm_out_4 = r[3];
    softmax_output_ready = 1;
    @(negedge clk);
    chk("ready_ignored_collect", 32'(m_valid), 0);
    chk("ready_ignored_busy", 32'(busy), 0);
    d = '{32'h5, 32'h7, 32'hFFFFFFFF, 32'h6};
    full_group(d, r, 0, 0);
    softmax_output_ready = 0;
    // timeout: 8 WAIT cycles then COLLECT with sticky error
    d = '{32'h1, 32'h2, 32'h3, 32'h4};
    send_group(d);
    for (int i = 0; i < 8; i++) begin
      chk("enable_until_timeout", 32'(softmax_enable), 1);
      @(negedge clk);
    end
    chk("timeout_err", 32'(timeout_err), 1);
    chk("timeout_float_inst", 32'(timeout_err_f), 1);
    chk("timeout_s_ready", 32'(s_ready), 1);
    chk("timeout_no_m_valid", 32'(m_valid), 0);
    @(negedge clk);
    chk("timeout_sticky", 32'(timeout_err), 1);
    r = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
    full_group(d, r, 3, 0);
    chk("timeout_still_sticky", 32'(timeout_err), 1);
    reset = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    // ready on the same cycle as the timeout wins
    r = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    full_group(d, r, 7, 0);
    chk("same_cycle_no_timeout", 32'(timeout_err), 0);
    // reset asserted in WAIT
    d = '{32'h9, 32'h8, 32'h7, 32'h6};
    send_group(d);
    reset = 0;
    #2;
    chk_reset_state();
    @(negedge clk);
    chk_reset_state();
    reset = 1;
    @(negedge clk);
    // reset asserted mid-DRAIN with two results already taken
    d = '{32'hFFFFFFF0, 32'h10, 32'h20, 32'hFFFFFFF8};
    r = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
    send_group(d);
    respond(1, r);
    drain(r, 2, 0);
    chk("drain_idx2_data", m_data, r[2]);
    reset = 0;
    @(negedge clk);
    chk_reset_state();
    reset = 1;
    @(negedge clk);
    d = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000003, 32'h00000002};
    r = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
    full_group(d, r, 2, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
